// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
// Optional macro CLA_PIPE_SAT_EN adds the sat_mode signal carried with each beat.
interface cla_pipe_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic             cout;
    logic             ovf;
`ifdef CLA_PIPE_SAT_EN
    logic             sat_mode;

    modport master (
        output in_valid, x, y, cin, sat_mode, out_ready,
        input  in_ready, out_valid, z, cout, ovf
    );
    modport slave (
        input  in_valid, x, y, cin, sat_mode, out_ready,
        output in_ready, out_valid, z, cout, ovf
    );
`else
    modport master (
        output in_valid, x, y, cin, out_ready,
        input  in_ready, out_valid, z, cout, ovf
    );
    modport slave (
        input  in_valid, x, y, cin, out_ready,
        output in_ready, out_valid, z, cout, ovf
    );
`endif
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder: {cout, z} = x + y + cin.
// Input register, STAGES carry stages (LSB-first groups), output register.
// Global stall: every register holds while out_valid & ~out_ready.
// Optional macro CLA_PIPE_SAT_EN adds signed saturation selected per beat by sat_mode.
module cla_pipe_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned GROUP  = 4,
    parameter int unsigned STAGES = 2
) (
    input logic            clk,
    input logic            rst,
    cla_pipe_adder_if.slave bus
);
    localparam int unsigned NG  = (GROUP == 0) ? 0 : WIDTH / GROUP;
    localparam int unsigned PER = (STAGES == 0) ? 1 : (NG + STAGES - 1) / STAGES;

    if ((GROUP == 0) || (WIDTH % GROUP != 0) || (STAGES == 0) || (STAGES > NG)) begin : g_bad_params
        $fatal(1, "cla_pipe_adder: illegal WIDTH/GROUP/STAGES combination");
    end

    logic             advance;
    logic             accept;
    logic             vld   [0:STAGES];
    logic [WIDTH-1:0] xs    [0:STAGES];
    logic [WIDTH-1:0] ys    [0:STAGES];
    logic [WIDTH-1:0] ps    [0:STAGES];
    logic             cs    [0:STAGES];
    logic [WIDTH-1:0] ps_nxt[1:STAGES];
    logic             cs_nxt[1:STAGES];
`ifdef CLA_PIPE_SAT_EN
    logic             sats  [0:STAGES];
`endif
    logic [WIDTH-1:0] z_nxt;
    logic             cout_nxt;
    logic             ovf_nxt;
    logic             msb_cin;
    logic             out_valid_q;
    logic [WIDTH-1:0] z_q;
    logic             cout_q;
    logic             ovf_q;

    // One lookahead group: every bit carry is a flat g/p product term of the group carry-in.
    function automatic logic [GROUP:0] cla_group(input logic [GROUP-1:0] a,
                                                 input logic [GROUP-1:0] b,
                                                 input logic             c);
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP:0]   cc;
        logic             term;
        g     = a & b;
        p     = a ^ b;
        cc    = '0;
        cc[0] = c;
        for (int unsigned j = 1; j <= GROUP; j++) begin
            term = c;
            for (int unsigned k = 0; k < j; k++) term = term & p[k];
            cc[j] = term;
            for (int unsigned k = 0; k < j; k++) begin
                term = g[k];
                for (int unsigned m = k + 1; m < j; m++) term = term & p[m];
                cc[j] = cc[j] | term;
            end
        end
        return {cc[GROUP], p ^ cc[GROUP-1:0]};
    endfunction

    // Stage s resolves groups [(s-1)*PER, min(s*PER, NG)); other partial-sum bits pass through.
    function automatic logic [WIDTH:0] resolve_stage(input int unsigned      s,
                                                     input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b,
                                                     input logic [WIDTH-1:0] p,
                                                     input logic             c);
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic [GROUP:0]   r;
        int unsigned      lo;
        int unsigned      hi;
        sum   = p;
        carry = c;
        lo    = (s - 1) * PER;
        hi    = s * PER;
        if (hi > NG) hi = NG;
        for (int unsigned gi = lo; gi < hi; gi++) begin
            r                       = cla_group(a[gi*GROUP +: GROUP], b[gi*GROUP +: GROUP], carry);
            sum[gi*GROUP +: GROUP]  = r[GROUP-1:0];
            carry                   = r[GROUP];
        end
        return {carry, sum};
    endfunction

    assign advance       = ~out_valid_q | bus.out_ready;
    assign bus.in_ready  = advance & ~rst;
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.z         = z_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

    // Carry/partial-sum resolution for each pipeline stage.
    always_comb begin
        for (int unsigned s = 1; s <= STAGES; s++) begin
            {cs_nxt[s], ps_nxt[s]} = resolve_stage(s, xs[s-1], ys[s-1], ps[s-1], cs[s-1]);
        end
    end

    // Final result: carry into MSB recovered from the sum bit, optional clamp on overflow.
    always_comb begin
        msb_cin  = ps[STAGES][WIDTH-1] ^ xs[STAGES][WIDTH-1] ^ ys[STAGES][WIDTH-1];
        cout_nxt = cs[STAGES];
        ovf_nxt  = cs[STAGES] ^ msb_cin;
        z_nxt    = ps[STAGES];
`ifdef CLA_PIPE_SAT_EN
        if (sats[STAGES] && ovf_nxt) begin
            z_nxt = xs[STAGES][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Valid chain and output register; cleared asynchronously so no stale beat survives reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i <= STAGES; i++) vld[i] <= 1'b0;
            out_valid_q <= 1'b0;
            z_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (advance) begin
            vld[0] <= accept;
            for (int unsigned s = 1; s <= STAGES; s++) vld[s] <= vld[s-1];
            out_valid_q <= vld[STAGES];
            z_q         <= z_nxt;
            cout_q      <= cout_nxt;
            ovf_q       <= ovf_nxt;
        end
    end

    // Datapath registers (no reset needed: qualified by the valid chain).
    always_ff @(posedge clk) begin
        if (advance) begin
            if (accept) begin
                xs[0] <= bus.x;
                ys[0] <= bus.y;
                cs[0] <= bus.cin;
                ps[0] <= '0;
`ifdef CLA_PIPE_SAT_EN
                sats[0] <= bus.sat_mode;
`endif
            end
            for (int unsigned s = 1; s <= STAGES; s++) begin
                xs[s] <= xs[s-1];
                ys[s] <= ys[s-1];
                ps[s] <= ps_nxt[s];
                cs[s] <= cs_nxt[s];
`ifdef CLA_PIPE_SAT_EN
                sats[s] <= sats[s-1];
`endif
            end
        end
    end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder (WIDTH=16, GROUP=4, STAGES=2).
// Inputs change 1 time unit after posedge; everything is sampled on negedge.
module tb_cla_pipe_adder;
    localparam int unsigned WIDTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cla_pipe_adder_if #(.WIDTH(WIDTH)) bus ();

    cla_pipe_adder #(.WIDTH(WIDTH), .GROUP(4), .STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] z;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic        lat_check = 1'b1;
    logic        stall_prev = 1'b0;
    logic [15:0] prev_z;
    logic        prev_cout;
    logic        prev_ovf;
    logic        acc;
    int          sent;
    int          t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic c,
                                   input logic sat, input int when);
        logic [16:0] s;
        exp_t        e;
        s      = {1'b0, a} + {1'b0, b} + {16'b0, c};
        e.z    = s[15:0];
        e.cout = s[16];
        e.ovf  = (a[15] == b[15]) && (s[15] != a[15]);
        if (sat && e.ovf) e.z = a[15] ? 16'h8000 : 16'h7FFF;
        e.cyc  = when;
        return e;
    endfunction

    // Monitor: push on input handshake, pop/compare on output handshake.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (bus.in_valid && bus.in_ready) begin
`ifdef CLA_PIPE_SAT_EN
                sb.push_back(model(bus.x, bus.y, bus.cin, bus.sat_mode, cyc));
`else
                sb.push_back(model(bus.x, bus.y, bus.cin, 1'b0, cyc));
`endif
            end
            check("in_ready", {31'b0, bus.in_ready}, {31'b0, (!bus.out_valid || bus.out_ready)});
            if (stall_prev) begin
                check("hold_valid", {31'b0, bus.out_valid}, 32'd1);
                check("hold_z", {16'b0, bus.z}, {16'b0, prev_z});
                check("hold_cout", {31'b0, bus.cout}, {31'b0, prev_cout});
                check("hold_ovf", {31'b0, bus.ovf}, {31'b0, prev_ovf});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("z", {16'b0, bus.z}, {16'b0, mon_e.z});
                    check("cout", {31'b0, bus.cout}, {31'b0, mon_e.cout});
                    check("ovf", {31'b0, bus.ovf}, {31'b0, mon_e.ovf});
                    // accepted at the posedge after the push sample, result 3 edges later
                    if (lat_check) check("latency", cyc - mon_e.cyc, 32'd4);
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_z     = bus.z;
            prev_cout  = bus.cout;
            prev_ovf   = bus.ovf;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // One cycle of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic ordy, output logic accepted);
        bus.in_valid  = v;
        bus.x         = a;
        bus.y         = b;
        bus.cin       = c;
        bus.out_ready = ordy;
        @(negedge clk);
        accepted = bus.in_valid & bus.in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic a;
        for (int k = 0; k < 40 && sb.size() != 0; k++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, a);
        repeat (4) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, a);
        check("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
`ifdef CLA_PIPE_SAT_EN
        bus.sat_mode  = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_z", {16'b0, bus.z}, 32'd0);
        check("rst_cout", {31'b0, bus.cout}, 32'd0);
        check("rst_ovf", {31'b0, bus.ovf}, 32'd0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // basic adds, full ripple, signed overflow
        step(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b1, acc);
        drain();
        step(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1, acc);
        drain();
        step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1, acc);
        step(1'b1, 16'h8000, 16'hFFFF, 1'b0, 1'b1, acc);
        drain();
`ifdef CLA_PIPE_SAT_EN
        bus.sat_mode = 1'b1;
        step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1, acc);
        step(1'b1, 16'h8000, 16'hFFFF, 1'b0, 1'b1, acc);
        step(1'b1, 16'h1000, 16'h2000, 1'b1, 1'b1, acc);
        bus.sat_mode = 1'b0;
        drain();
`endif

        // back-to-back stream with output stall on cycles 4..6
        lat_check = 1'b0;
        sent = 0;
        t = 0;
        while (sent < 8 && t < 60) begin
            step(1'b1, 16'(sent), 16'(sent * 16'h1000), 1'b0, !(t >= 4 && t <= 6), acc);
            if (acc) sent++;
            t++;
        end
        check("stream_sent", sent, 32'd8);
        drain();
        lat_check = 1'b1;

        // bubbles: valid pattern 1,0,1,0 must reappear at the output unchanged
        step(1'b1, 16'h00AA, 16'h0055, 1'b0, 1'b1, acc);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, acc);
        step(1'b1, 16'hABCD, 16'h1111, 1'b1, 1'b1, acc);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, acc);
        drain();

        // reset with beats in flight: first result already on the output
        step(1'b1, 16'h0101, 16'h0202, 1'b0, 1'b1, acc);
        step(1'b1, 16'h0303, 16'h0404, 1'b0, 1'b1, acc);
        step(1'b1, 16'h0505, 16'h0606, 1'b0, 1'b1, acc);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, acc);
        check("pre_rst_out_valid", {31'b0, bus.out_valid}, 32'd1);
        rst = 1'b1;
        sb.delete();
        #1;
        check("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("mid_rst_z", {16'b0, bus.z}, 32'd0);
        check("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b1, acc);
        drain();

        // random traffic with random backpressure
        lat_check = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0), acc);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined successor to the team's registered 4-bit carry-lookahead adder.
- Adds two WIDTH-bit operands plus carry-in using GROUP-bit CLA groups chained across STAGES pipeline stages.
- Registered inputs and outputs, with a valid/ready handshake on both sides.
- Sits between operand sources and a result consumer in datapath blocks that need a wide add at high clock rate.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of GROUP.
- GROUP, 4, bits per carry-lookahead group (generate/propagate computed per group).
- STAGES, 2, carry pipeline stages after the input register; legal range 1..WIDTH/GROUP.

Ports:
- clk, input, 1, sole clock; all state updates on rising edge.
- rst, input, 1, asynchronous, active-high reset.
- in_valid, input, 1, operand beat present.
- in_ready, output, 1, block accepts a beat this cycle.
- x, input, WIDTH, operand A.
- y, input, WIDTH, operand B.
- cin, input, 1, carry-in.
- out_valid, output, 1, result beat present.
- out_ready, input, 1, consumer accepts result.
- z, output, WIDTH, sum bits.
- cout, output, 1, carry-out of the MSB.
- ovf, output, 1, signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async, rst=1): all pipeline valid bits = 0, z = 0, cout = 0, ovf = 0, in_ready = 0 while rst is high. Data registers need not clear, except the output register.
- Pipeline structure:
  - Input register captures x, y, cin on handshake (in_valid & in_ready).
  - Carry stages: NG = WIDTH/GROUP groups assigned to STAGES stages in LSB-first order.
  - Each stage resolves ceil(NG/STAGES) groups; the last stage takes the remainder.
  - Each stage forwards the resolved carry and partial sum; unresolved operand bits travel alongside.
  - Output register holds z/cout/ovf.
- Latency: 1 + STAGES cycles from accepted input to out_valid when there is no backpressure. Defaults give 3.
- Throughput: one result per cycle when out_ready is held 1.
- Flow control is a global stall:
  - advance = ~out_valid | out_ready.
  - in_ready = advance & ~rst.
  - When advance = 0, every stage and the output hold their contents; inputs are not sampled.
- Bubbles: cycles with in_valid = 0 insert valid = 0 slots that propagate. Bubbles do not compress while advance = 1.
- Output stability: z/cout/ovf/out_valid must not change while out_valid = 1 and out_ready = 0.
- Arithmetic: {cout, z} = x + y + cin, unsigned, modulo 2^(WIDTH+1). ovf follows the signed two's-complement rule.
- Wrap-around: all-ones + 1 gives z = 0, cout = 1; carry must ripple through every group and every stage correctly.
- Simultaneous events: an output drain and an input accept in the same cycle both occur; no beat is lost or duplicated.
- Reset mid-operation: all in-flight beats are discarded; out_valid drops asynchronously; no partial result is ever presented after reset release.
- Elaboration check: an illegal parameter combination (WIDTH % GROUP != 0, or STAGES out of range) is a fatal elaboration error.

Optional Feature:
- Macro: CLA_PIPE_SAT_EN.
- Defined:
  - Adds input port sat_mode (1 bit), sampled with the operands and carried with the beat.
  - When sat_mode = 1 and ovf = 1, z clamps to the signed maximum (0111..1) if x[MSB] = 0, else to the signed minimum (100..0).
  - cout and ovf still report the raw unsaturated result.
  - Latency is unchanged.
- Undefined: no sat_mode port; z is always the raw sum.

Test Plan (WIDTH=16, GROUP=4, STAGES=2):
- Reset, then x=0x1234, y=0x4321, cin=0, out_ready=1 -> out_valid exactly 3 cycles later, z=0x5555, cout=0, ovf=0.
- x=0xFFFF, y=0x0000, cin=1 -> z=0x0000, cout=1, ovf=0 (full carry ripple across both stages).
- x=0x7FFF, y=0x0001, cin=0 -> z=0x8000, cout=0, ovf=1. With CLA_PIPE_SAT_EN and sat_mode=1 -> z=0x7FFF, ovf=1.
- Back-to-back stream of 8 beats (x=i, y=i*0x1000, i=0..7), out_ready low for cycles 4-6 -> in_ready low during stall, outputs held stable, all 8 results in order, no drops or duplicates.
- in_valid toggling 1,0,1,0 with out_ready=1 -> out_valid toggles identically 3 cycles later.
- Assert rst for 1 cycle while 3 beats are in flight -> out_valid=0 immediately, z=0. After release, a new beat x=1, y=2 -> z=3 after 3 cycles, no stale results.
